// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - iterative SLL/SRL/SRA unit, 4-bit or 1-bit step per cycle
// One operation in flight; valid/ready handshake on both request and result.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SW-1:0] FOUR = SW'(4);
  localparam logic [SW-1:0] ONE  = SW'(1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    rem;
  logic [1:0]       op;

  logic             big_step;
  logic [WIDTH-1:0] shifted;
  logic [SW-1:0]    rem_next;

  assign big_step = (rem >= FOUR);
  assign rem_next = big_step ? (rem - FOUR) : (rem - ONE);

  // Arithmetic right fills from acc's own MSB, which every step preserves.
  always_comb begin
    shifted = acc;
    case (op)
      2'b01: shifted = big_step ? {4'b0000, acc[WIDTH-1:4]}
                                : {1'b0, acc[WIDTH-1:1]};
      2'b11: shifted = big_step ? {{4{acc[WIDTH-1]}}, acc[WIDTH-1:4]}
                                : {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: shifted = big_step ? {acc[WIDTH-5:0], 4'b0000}
                                  : {acc[WIDTH-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      op    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= in_data;
            rem   <= in_shamt;
            op    <= in_op;
            state <= (in_shamt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc <= shifted;
          rem <= rem_next;
          if (rem_next == '0) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = acc;

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - randomized self-checking bench for iter_shifter
// Golden model uses plain <<, >>, >>> and the floor(s/4)+(s mod 4) latency rule.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int errors = 0;
  int checks = 0;

  iter_shifter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input logic [31:0] d, input int s, input logic [1:0] op);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b01:   return d >> s;
      2'b11:   return 32'(sd >>> s);
      default: return d << s;
    endcase
  endfunction

  function automatic int latency(input int s);
    return s / 4 + s % 4;
  endfunction

  // Present a request and let the next rising edge accept it.
  task automatic start_op(input logic [31:0] d, input int s, input logic [1:0] op);
    in_data  = d;
    in_shamt = 5'(s);
    in_op    = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_op    = 2'($urandom);
  endtask

  // Bounded wait for out_valid; counts edges after accept and notes any in_ready.
  task automatic wait_result(output int cycles, output bit ready_seen);
    cycles = 0;
    ready_seen = 1'b0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (in_ready) ready_seen = 1'b1;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sll_max();
    int cyc; bit rdy;
    start_op(32'h0000_0001, 31, 2'b00);
    wait_result(cyc, rdy);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sll31_timeout got=%b exp=1", out_valid); end
    checks++; if (cyc != 10) begin errors++; $display("FAIL sll31_latency got=%0d exp=10", cyc); end
    checks++; if (out_data !== 32'h8000_0000) begin errors++; $display("FAIL sll31_data got=%h exp=80000000", out_data); end
    checks++; if (rdy || in_ready !== 1'b0) begin errors++; $display("FAIL sll31_in_ready got=%b/%b exp=0", rdy, in_ready); end
    finish_op();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL sll31_idle got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_right_shifts();
    logic [31:0] d[3]   = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFF0};
    int          s[3]   = '{4, 5, 3};
    logic [1:0]  o[3]   = '{2'b11, 2'b01, 2'b11};
    logic [31:0] e[3]   = '{32'hF800_0000, 32'h0400_0000, 32'h0FFF_FFFE};
    int          n[3]   = '{1, 2, 3};
    int cyc; bit rdy;
    for (int i = 0; i < 3; i++) begin
      start_op(d[i], s[i], o[i]);
      wait_result(cyc, rdy);
      checks++; if (cyc != n[i] || out_valid !== 1'b1) begin errors++; $display("FAIL right%0d_latency got=%0d/%b exp=%0d/1", i, cyc, out_valid, n[i]); end
      checks++; if (out_data !== e[i]) begin errors++; $display("FAIL right%0d_data got=%h exp=%h", i, out_data, e[i]); end
      finish_op();
    end
  endtask

  task automatic test_zero_reserved();
    start_op(32'hDEAD_BEEF, 0, 2'b10);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_data got=%h exp=deadbeef", out_data); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int cyc; bit rdy;
    start_op(32'hF0F0_F0F0, 8, 2'b01);
    wait_result(cyc, rdy);
    checks++; if (cyc != 2 || out_data !== 32'h00F0_F0F0) begin errors++; $display("FAIL bp_result got=%0d/%h exp=2/00f0f0f0", cyc, out_data); end
    in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'd0; in_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h00F0_F0F0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/00f0f0f0/0", i, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got=%b/%b exp=1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin errors++; $display("FAIL bp_next got=%b/%h exp=1/12345678", out_valid, out_data); end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int cyc; bit rdy;
    start_op(32'h0000_0001, 31, 2'b00);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++; $display("FAIL rstmid_async got=%b/%b/%h exp=0/1/0", out_valid, in_ready, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_op(32'h0000_0003, 1, 2'b00);
    wait_result(cyc, rdy);
    checks++; if (cyc != 1 || out_data !== 32'h0000_0006) begin errors++; $display("FAIL rstmid_next got=%0d/%h exp=1/00000006", cyc, out_data); end
    finish_op();
  endtask

  task automatic test_random();
    int cyc; bit rdy; int s; int stall;
    logic [31:0] d, exp_d; logic [1:0] op;
    for (int k = 0; k < 1500; k++) begin
      d = $urandom; s = $urandom_range(0, 31); op = 2'($urandom);
      exp_d = golden(d, s, op);
      start_op(d, s, op);
      wait_result(cyc, rdy);
      checks++;
      if (out_valid !== 1'b1 || cyc != latency(s) || rdy || out_data !== exp_d) begin
        errors++;
        $display("FAIL rand%0d op=%0d s=%0d d=%h got=%h/%0d/%b exp=%h/%0d/1", k, op, s, d, out_data, cyc, out_valid, exp_d, latency(s));
      end
      stall = $urandom_range(0, 3);
      for (int j = 0; j < stall; j++) begin
        in_valid = $urandom_range(0, 1);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_d) begin
          errors++; $display("FAIL rand%0d_stall got=%b/%h exp=1/%h", k, out_valid, out_data, exp_d);
        end
      end
      in_valid = 1'b0;
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_sll_max();
    test_right_shifts();
    test_zero_reserved();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
